// File: rtl/div_sched_if.sv
// Bundle of requester, response and shared-divider signals for div_sched.
// The scheduler connects through the slave modport; the environment through master.
interface div_sched_if #(
    parameter int N      = 4,
    parameter int LENGTH = 20
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]        req;
    logic [N*LENGTH-1:0] req_dividend;
    logic [N*LENGTH-1:0] req_divisor;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        rsp_valid;
    logic [N-1:0]        rsp_ready;
    logic [LENGTH-1:0]   rsp_quo;
    logic                rsp_dz;
    logic                rsp_err;
    logic                div_start;
    logic [LENGTH-1:0]   div_dividend;
    logic [LENGTH-1:0]   div_divisor;
    logic                div_done;
    logic [LENGTH-1:0]   div_quo;
    logic                busy;
    logic [GW-1:0]       grant_id;

    modport slave (
        input  req, req_dividend, req_divisor, rsp_ready, div_done, div_quo,
        output req_ready, rsp_valid, rsp_quo, rsp_dz, rsp_err,
               div_start, div_dividend, div_divisor, busy, grant_id
    );

    modport master (
        output req, req_dividend, req_divisor, rsp_ready, div_done, div_quo,
        input  req_ready, rsp_valid, rsp_quo, rsp_dz, rsp_err,
               div_start, div_dividend, div_divisor, busy, grant_id
    );
endinterface

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one multi-cycle divider among N requesters.
// Divide-by-zero is answered locally; divider waits are bounded by a timeout.
module div_sched #(
    parameter int N       = 4,
    parameter int LENGTH  = 20,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input logic        clk,
    input logic        rst,
    div_sched_if.slave bus
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [GW-1:0] LAST_RESET = GW'(N - 1);
    localparam logic [TW-1:0] CNT_LAST   = TW'(TIMEOUT - 1);
    localparam logic [N-1:0]  ONE        = N'(1);

    logic [1:0]        state_q, state_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [LENGTH-1:0] dividend_q, dividend_d;
    logic [LENGTH-1:0] divisor_q, divisor_d;
    logic [LENGTH-1:0] quo_q, quo_d;
    logic              dz_q, dz_d;
    logic              err_q, err_d;
    logic [TW-1:0]     cnt_q, cnt_d;

    logic              win_found;
    logic [GW-1:0]     win_idx;
    logic [LENGTH-1:0] win_dividend;
    logic [LENGTH-1:0] win_divisor;
    logic [N-1:0]      req_rot;
    logic [N-1:0]      req_ready_c;
    int                pos;

    // Rotating the doubled request vector puts last_grant+1 at bit 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        pos       = 0;
        req_rot   = N'({bus.req, bus.req} >> (int'(last_grant_q) + 1));
        for (int k = 0; k < N; k++) begin
            if (!win_found && req_rot[k]) begin
                win_found = 1'b1;
                pos       = int'(last_grant_q) + 1 + k;
                if (pos >= N) pos = pos - N;
                win_idx   = GW'(pos);
            end
        end
    end

    always_comb begin
        win_dividend = '0;
        win_divisor  = '0;
        for (int i = 0; i < N; i++) begin
            if (win_idx == GW'(i)) begin
                win_dividend = bus.req_dividend[i*LENGTH +: LENGTH];
                win_divisor  = bus.req_divisor[i*LENGTH +: LENGTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        quo_d        = quo_q;
        dz_d         = dz_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        req_ready_c  = '0;
        case (state_q)
            S_IDLE: begin
                if (rst && win_found) begin
                    req_ready_c = ONE << win_idx;
                    grant_d     = win_idx;
                    dividend_d  = win_dividend;
                    divisor_d   = win_divisor;
                    if (win_divisor == '0) begin
                        quo_d   = '1;
                        dz_d    = 1'b1;
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the final timeout cycle still counts as success.
                if (bus.div_done) begin
                    quo_d   = bus.div_quo;
                    dz_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    quo_d   = '0;
                    dz_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= LAST_RESET;
            grant_q      <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            quo_q        <= '0;
            dz_q         <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            quo_q        <= quo_d;
            dz_q         <= dz_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.rsp_valid    = (state_q == S_RESP) ? (ONE << grant_q) : '0;
    assign bus.rsp_quo      = quo_q;
    assign bus.rsp_dz       = dz_q;
    assign bus.rsp_err      = err_q;
    assign bus.div_start    = (state_q == S_ISSUE);
    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.grant_id     = grant_q;
endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed vector table, reset/round-robin
// sequences, and randomized traffic against a transaction-level scoreboard.
module tb_div_sched;
    localparam int N       = 4;
    localparam int LENGTH  = 20;
    localparam int TIMEOUT = 64;
    localparam int TW      = 7;

    typedef logic [LENGTH-1:0] word_t;

    typedef struct {
        int    id;
        word_t dvd;
        word_t dvs;
        int    lat;
        int    hold;
        word_t exp_quo;
        bit    exp_dz;
        bit    exp_err;
        int    exp_rlat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    div_sched_if #(.N(N), .LENGTH(LENGTH)) bus ();

    div_sched #(.N(N), .LENGTH(LENGTH), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    vec_count  = 0;
    int    miss_count = 0;
    int    cyc        = 0;
    int    model_last = N - 1;
    int    grants[$];
    vec_t  vecs[$];
    word_t op_a[N];
    word_t op_b[N];

    // Divider model: answers div_lat cycles after the start pulse (0 = never).
    int    div_lat        = 1;
    bit    div_lat_random = 1'b0;
    bit    div_active     = 1'b0;
    int    div_k          = 0;
    int    done_cycle     = -1;
    word_t div_a, div_b;

    task checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task step();
        @(posedge clk);
        #1;
        cyc++;
        bus.div_done = 1'b0;
        if (div_active) begin
            div_k++;
            if (div_k == div_lat) begin
                bus.div_done = 1'b1;
                bus.div_quo  = div_a / div_b;
                div_active   = 1'b0;
                done_cycle   = cyc;
            end
        end
        if (bus.div_start === 1'b1) begin
            div_a = bus.div_dividend;
            div_b = bus.div_divisor;
            div_k = 0;
            if (div_lat_random) div_lat = $urandom_range(1, 6);
            div_active = (div_lat > 0);
        end
    endtask

    task settle();
        #2;
    endtask

    task scramble_ops();
        for (int i = 0; i < N; i++) begin
            op_a[i] = word_t'($urandom);
            op_b[i] = ($urandom_range(0, 7) == 0) ? '0 : word_t'($urandom_range(1, 4095));
        end
    endtask

    task drive_ops();
        for (int i = 0; i < N; i++) begin
            bus.req_dividend[i*LENGTH +: LENGTH] = op_a[i];
            bus.req_divisor[i*LENGTH +: LENGTH]  = op_b[i];
        end
    endtask

    task doReset();
        rst           = 1'b0;
        bus.req       = '0;
        bus.rsp_ready = '0;
        step();
        rst          = 1'b1;
        div_active   = 1'b0;
        bus.div_done = 1'b0;
        model_last   = N - 1;
        settle();
        checkOutput("reset_busy", bus.busy, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [N-1:0] mask;
        int           rlat;
        int           starts;
        bit           seen;
        mask           = onehot(v.id);
        div_lat        = v.lat;
        div_lat_random = 1'b0;
        scramble_ops();
        op_a[v.id] = v.dvd;
        op_b[v.id] = v.dvs;
        drive_ops();
        bus.req       = mask;
        bus.rsp_ready = '0;
        settle();
        checkOutput("req_ready", bus.req_ready, mask);
        checkOutput("busy_idle", bus.busy, 0);
        step();
        rlat   = 0;
        starts = 0;
        seen   = 1'b0;
        // Inputs churn while busy; none of it may reach the operation in flight.
        for (int t = 1; t <= 200 && !seen; t++) begin
            scramble_ops();
            drive_ops();
            bus.req = N'($urandom);
            settle();
            if (bus.div_start === 1'b1) starts++;
            if (t == 1 && !v.exp_dz) begin
                checkOutput("div_start", bus.div_start, 1);
                checkOutput("div_dividend", bus.div_dividend, v.dvd);
                checkOutput("div_divisor", bus.div_divisor, v.dvs);
            end
            if (bus.rsp_valid !== '0) begin
                seen = 1'b1;
                rlat = t;
            end else begin
                step();
            end
        end
        checkOutput("rsp_seen", seen, 1);
        checkOutput("rsp_latency", rlat, v.exp_rlat);
        checkOutput("rsp_valid", bus.rsp_valid, mask);
        checkOutput("rsp_quo", bus.rsp_quo, v.exp_quo);
        checkOutput("rsp_dz", bus.rsp_dz, v.exp_dz);
        checkOutput("rsp_err", bus.rsp_err, v.exp_err);
        checkOutput("grant_id", bus.grant_id, v.id);
        checkOutput("busy_resp", bus.busy, 1);
        checkOutput("start_count", starts, v.exp_dz ? 0 : 1);
        if (!v.exp_dz) checkOutput("div_dividend_hold", bus.div_dividend, v.dvd);
        for (int h = 0; h < v.hold; h++) begin
            bus.rsp_ready = ~mask;
            bus.req       = '1;
            step();
            settle();
            checkOutput("bp_rsp_valid", bus.rsp_valid, mask);
            checkOutput("bp_rsp_quo", bus.rsp_quo, v.exp_quo);
            checkOutput("bp_grant_id", bus.grant_id, v.id);
            checkOutput("bp_req_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = mask;
        bus.req       = '0;
        step();
        bus.rsp_ready = '0;
        model_last    = v.id;
        settle();
        checkOutput("rsp_release", bus.rsp_valid, 0);
        checkOutput("busy_release", bus.busy, 0);
    endtask

    task resetInWait();
        div_lat        = 0;
        div_lat_random = 1'b0;
        op_a[2] = word_t'(30);
        op_b[2] = word_t'(5);
        drive_ops();
        bus.req = 4'b0100;
        settle();
        checkOutput("riw_req_ready", bus.req_ready, 4'b0100);
        step();
        bus.req = '0;
        step();
        step();
        settle();
        checkOutput("riw_busy", bus.busy, 1);
        rst = 1'b0;
        step();
        rst          = 1'b1;
        div_active   = 1'b0;
        model_last   = N - 1;
        bus.div_done = 1'b1;
        bus.div_quo  = word_t'(123);
        settle();
        checkOutput("riw_busy0", bus.busy, 0);
        checkOutput("riw_rsp_valid0", bus.rsp_valid, 0);
        checkOutput("riw_grant_id", bus.grant_id, 0);
        checkOutput("riw_div_dividend", bus.div_dividend, 0);
        checkOutput("riw_div_divisor", bus.div_divisor, 0);
        checkOutput("riw_rsp_quo", bus.rsp_quo, 0);
        checkOutput("riw_rsp_err", bus.rsp_err, 0);
        checkOutput("riw_div_start", bus.div_start, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            checkOutput("riw_late_done", bus.rsp_valid, 0);
            checkOutput("riw_idle", bus.busy, 0);
        end
    endtask

    // Scoreboard: one outstanding job, round-robin winner from the last served id.
    task automatic run_traffic(input int cycles, input bit rand_mode);
        bit           outstanding;
        bit           due;
        int           pend_id, pend_cycle, pick;
        word_t        pend_a, pend_b, exp_q;
        logic [N-1:0] req_v, rdy_v, exp_rr, exp_rv;
        outstanding = 1'b0;
        pend_id     = 0;
        pend_cycle  = 0;
        pend_a      = '0;
        pend_b      = '0;
        done_cycle  = -1;
        grants.delete();
        for (int c = 0; c < cycles; c++) begin
            scramble_ops();
            drive_ops();
            req_v = rand_mode ? N'($urandom) : '1;
            rdy_v = rand_mode ? N'($urandom) : '1;
            bus.req       = req_v;
            bus.rsp_ready = rdy_v;
            settle();
            pick   = rr_pick(model_last, req_v);
            exp_rr = (!outstanding && pick >= 0) ? onehot(pick) : '0;
            checkOutput("tr_req_ready", bus.req_ready, exp_rr);
            checkOutput("tr_div_start", bus.div_start,
                        outstanding && pend_b != '0 && cyc == pend_cycle + 1);
            due = outstanding && ((pend_b == '0) ? (cyc > pend_cycle)
                                                 : (done_cycle > pend_cycle && cyc > done_cycle));
            exp_rv = due ? onehot(pend_id) : '0;
            checkOutput("tr_rsp_valid", bus.rsp_valid, exp_rv);
            if (due) begin
                exp_q = (pend_b == '0) ? '1 : pend_a / pend_b;
                checkOutput("tr_rsp_quo", bus.rsp_quo, exp_q);
                checkOutput("tr_rsp_dz", bus.rsp_dz, pend_b == '0);
                checkOutput("tr_rsp_err", bus.rsp_err, 0);
                checkOutput("tr_grant_id", bus.grant_id, pend_id);
                if (rdy_v[pend_id]) begin
                    outstanding = 1'b0;
                    model_last  = pend_id;
                end
            end else if (!outstanding && pick >= 0) begin
                outstanding = 1'b1;
                pend_id     = pick;
                pend_a      = op_a[pick];
                pend_b      = op_b[pick];
                pend_cycle  = cyc;
                grants.push_back(pick);
            end
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        bus.req          = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.rsp_ready    = '0;
        bus.div_done     = 1'b0;
        bus.div_quo      = '0;

        //         id  dividend        divisor     lat hold quotient       dz    err   rlat
        vecs.push_back('{0, word_t'(100),   word_t'(7),   1,  0, word_t'(14),    1'b0, 1'b0, 3});
        vecs.push_back('{1, word_t'(1000),  word_t'(10),  3,  2, word_t'(100),   1'b0, 1'b0, 5});
        vecs.push_back('{2, word_t'(55),    word_t'(0),   1,  0, 20'hFFFFF,      1'b1, 1'b0, 1});
        vecs.push_back('{3, 20'hFFFFF,      word_t'(1),   2,  0, 20'hFFFFF,      1'b0, 1'b0, 4});
        vecs.push_back('{0, word_t'(5),     word_t'(9),   0,  0, word_t'(0),     1'b0, 1'b1, TIMEOUT + 2});
        vecs.push_back('{3, word_t'(12345), word_t'(123), 5, 10, word_t'(100),   1'b0, 1'b0, 7});
        vecs.push_back('{1, word_t'(7),     word_t'(0),   1,  3, 20'hFFFFF,      1'b1, 1'b0, 1});
        vecs.push_back('{2, word_t'(20),    word_t'(20),  6,  1, word_t'(1),     1'b0, 1'b0, 8});

        rst     = 1'b0;
        bus.req = '1;
        step();
        step();
        settle();
        checkOutput("rst_req_ready", bus.req_ready, 0);
        checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("rst_div_start", bus.div_start, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_grant_id", bus.grant_id, 0);
        checkOutput("rst_rsp_quo", bus.rsp_quo, 0);
        checkOutput("rst_rsp_dz", bus.rsp_dz, 0);
        checkOutput("rst_rsp_err", bus.rsp_err, 0);
        checkOutput("rst_div_dividend", bus.div_dividend, 0);
        checkOutput("rst_div_divisor", bus.div_divisor, 0);
        rst        = 1'b1;
        bus.req    = '0;
        model_last = N - 1;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        resetInWait();

        div_lat        = 3;
        div_lat_random = 1'b0;
        run_traffic(40, 1'b0);
        checkOutput("rr_grant_count", grants.size() >= 5, 1);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            checkOutput($sformatf("rr_order%0d", i), grants[i], exp_order[i]);

        doReset();
        div_lat_random = 1'b1;
        run_traffic(2000, 1'b1);
        doReset();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule
